// File: rtl/pipo_share_arbiter.sv
// Round-robin arbiter/sequencer that loads one requester's word into a shared PIPO register.
// Latency: req sampled at edge k -> gnt/q/q_valid visible after edge k; q held HOLD cycles.
// Backpressure: requesters keep req high until they see gnt; req is ignored while busy.
module pipo_share_arbiter #(
    parameter int n    = 3,
    parameter int R    = 4,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req,
    input  logic [R*n-1:0]       a,
    input  logic                 flush,
    output logic [R-1:0]         gnt,
    output logic [n-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(R)-1:0] q_owner,
    output logic                 busy
);

    localparam int IW = $clog2(R);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(R - 1);
    localparam logic [R-1:0]  ONE_HOT0 = R'(1);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;

    // Round-robin search: first set req bit starting at ptr, wrapping modulo R.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < R; k++) begin
            cand = IW'((int'(ptr) + k) % R);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Busy simply mirrors the HOLD state so requesters can see the register is taken.
    assign busy = (state == ST_HOLD);

    // Sequencer: grant and load in IDLE, count down the hold, release on expiry or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            q       <= '0;
            q_valid <= 1'b0;
            gnt     <= '0;
            q_owner <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt <= '0;
                    // flush in IDLE suppresses any new grant on this edge
                    if (!flush && found) begin
                        q       <= a[win*n +: n];
                        q_owner <= win;
                        gnt     <= ONE_HOT0 << win;
                        q_valid <= 1'b1;
                        cnt     <= CNT_INIT;
                        ptr     <= (win == LAST_IDX) ? '0 : win + 1'b1;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // grant is a single-cycle pulse; req is not looked at here
                    gnt <= '0;
                    if (flush || cnt == '0) begin
                        // q and q_owner keep the last word for observation
                        q_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_share_arbiter.sv
module tb_pipo_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [11:0] a   = 12'd0;
    logic        flush = 1'b0;
    logic [3:0]  gnt;
    logic [2:0]  q;
    logic        q_valid;
    logic [1:0]  q_owner;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pipo_share_arbiter #(.n(3), .R(4), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .req(req), .a(a), .flush(flush),
        .gnt(gnt), .q(q), .q_valid(q_valid), .q_owner(q_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Async reset applied with no clock edge in between; all outputs must clear at once.
    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, q, q_valid, q_owner, busy} !== 11'b0) begin
            errors++;
            $display("FAIL reset_init got gnt=%b q=%b qv=%b own=%0d busy=%b exp all 0",
                     gnt, q, q_valid, q_owner, busy);
        end
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    // Requester 2 alone: one grant pulse, word held two cycles, then released.
    task automatic test_single();
        a   = 12'b000_101_000_000;
        req = 4'b0100;
        cyc();
        checks++;
        if ({gnt, q, q_valid, q_owner, busy} !== {4'b0100, 3'b101, 1'b1, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got gnt=%b q=%b qv=%b own=%0d busy=%b exp gnt=0100 q=101 qv=1 own=2 busy=1",
                     gnt, q, q_valid, q_owner, busy);
        end
        req = 4'b0000;
        cyc();
        checks++;
        if ({gnt, q, q_valid, busy} !== {4'b0000, 3'b101, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_hold2 got gnt=%b q=%b qv=%b busy=%b exp gnt=0000 q=101 qv=1 busy=1",
                     gnt, q, q_valid, busy);
        end
        cyc();
        checks++;
        if ({gnt, q, q_valid, q_owner, busy} !== {4'b0000, 3'b101, 1'b0, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL single_release got gnt=%b q=%b qv=%b own=%0d busy=%b exp gnt=0000 q=101 qv=0 own=2 busy=0",
                     gnt, q, q_valid, q_owner, busy);
        end
    endtask

    // Reset asserted between edges during HOLD: the in-flight word is dropped immediately.
    task automatic test_reset_mid_hold();
        a   = 12'b000_000_000_011;
        req = 4'b0001;          // ptr is 3 here, search 3,0 -> requester 0
        cyc();
        checks++;
        if ({gnt, q, q_valid, q_owner, busy} !== {4'b0001, 3'b011, 1'b1, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_grant got gnt=%b q=%b qv=%b own=%0d busy=%b exp gnt=0001 q=011 qv=1 own=0 busy=1",
                     gnt, q, q_valid, q_owner, busy);
        end
        req = 4'b0000;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, q, q_valid, q_owner, busy} !== 11'b0) begin
            errors++;
            $display("FAIL midrst_clear got gnt=%b q=%b qv=%b own=%0d busy=%b exp all 0",
                     gnt, q, q_valid, q_owner, busy);
        end
        cyc();
        rst = 1'b1;
    endtask

    // All four requesting continuously: rotation 0,1,2,3,0 with grants three cycles apart.
    task automatic test_contention();
        logic [2:0] word [4];
        int         order [5];
        logic [3:0] exp_gnt;
        word[0] = 3'b001; word[1] = 3'b010; word[2] = 3'b110; word[3] = 3'b111;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        a   = {word[3], word[2], word[1], word[0]};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << order[g];
            cyc();
            checks++;
            if ({gnt, q, q_valid, q_owner} !== {exp_gnt, word[order[g]], 1'b1, 2'(order[g])}) begin
                errors++;
                $display("FAIL contend_grant%0d got gnt=%b q=%b qv=%b own=%0d exp gnt=%b q=%b qv=1 own=%0d",
                         g, gnt, q, q_valid, q_owner, exp_gnt, word[order[g]], order[g]);
            end
            cyc();
            checks++;
            if ({gnt, q_valid} !== {4'b0000, 1'b1}) begin
                errors++;
                $display("FAIL contend_hold%0d got gnt=%b qv=%b exp gnt=0000 qv=1", g, gnt, q_valid);
            end
            if (g == 4) req = 4'b0000;
            cyc();
            checks++;
            if ({gnt, q_valid, busy} !== {4'b0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL contend_gap%0d got gnt=%b qv=%b busy=%b exp gnt=0000 qv=0 busy=0",
                         g, gnt, q_valid, busy);
            end
        end
    endtask

    // Requester 1 raises req during requester 3's HOLD; it is served only after IDLE.
    task automatic test_late();
        req = 4'b1000;          // ptr is 1
        cyc();
        checks++;
        if ({gnt, q, q_owner} !== {4'b1000, 3'b111, 2'd3}) begin
            errors++;
            $display("FAIL late_first got gnt=%b q=%b own=%0d exp gnt=1000 q=111 own=3", gnt, q, q_owner);
        end
        req = 4'b0010;
        cyc();
        checks++;
        if ({gnt, q_valid} !== {4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL late_hold got gnt=%b qv=%b exp gnt=0000 qv=1", gnt, q_valid);
        end
        cyc();
        checks++;
        if ({gnt, q_valid, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL late_idle got gnt=%b qv=%b busy=%b exp gnt=0000 qv=0 busy=0", gnt, q_valid, busy);
        end
        cyc();
        checks++;
        if ({gnt, q, q_valid, q_owner} !== {4'b0010, 3'b010, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL late_second got gnt=%b q=%b qv=%b own=%0d exp gnt=0010 q=010 qv=1 own=1",
                     gnt, q, q_valid, q_owner);
        end
        req = 4'b0000;
        cyc();
        cyc();
    endtask

    // Flush cuts the hold short and blocks a grant while asserted in IDLE.
    task automatic test_flush();
        req = 4'b0100;          // ptr is 2
        cyc();
        checks++;
        if ({gnt, q, q_valid} !== {4'b0100, 3'b110, 1'b1}) begin
            errors++;
            $display("FAIL flush_grant got gnt=%b q=%b qv=%b exp gnt=0100 q=110 qv=1", gnt, q, q_valid);
        end
        req   = 4'b0000;
        flush = 1'b1;
        cyc();
        checks++;
        if ({gnt, q, q_valid, busy} !== {4'b0000, 3'b110, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_abort got gnt=%b q=%b qv=%b busy=%b exp gnt=0000 q=110 qv=0 busy=0",
                     gnt, q, q_valid, busy);
        end
        req = 4'b0001;
        cyc();
        checks++;
        if ({gnt, q_valid, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL flush_idle got gnt=%b qv=%b busy=%b exp gnt=0000 qv=0 busy=0", gnt, q_valid, busy);
        end
        flush = 1'b0;
        cyc();
        checks++;
        if ({gnt, q, q_owner} !== {4'b0001, 3'b001, 2'd0}) begin
            errors++;
            $display("FAIL flush_after got gnt=%b q=%b own=%0d exp gnt=0001 q=001 own=0", gnt, q, q_owner);
        end
        req = 4'b0000;
        cyc();
        cyc();
    endtask

    // Winner 3 wraps ptr to 0; then 1001 goes to requester 0 and ptr lands on 1.
    task automatic test_wrap();
        req = 4'b1000;          // ptr is 1
        cyc();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_last3 got gnt=%b exp 1000", gnt);
        end
        req = 4'b1001;          // raised during HOLD, evaluated once IDLE
        cyc();
        cyc();
        cyc();
        checks++;
        if ({gnt, q_owner} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL wrap_grant0 got gnt=%b own=%0d exp gnt=0001 own=0", gnt, q_owner);
        end
        req = 4'b0011;
        cyc();
        cyc();
        cyc();
        checks++;
        if ({gnt, q_owner} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL wrap_ptr1 got gnt=%b own=%0d exp gnt=0010 own=1", gnt, q_owner);
        end
        req = 4'b0000;
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        cyc();
        test_single();
        test_reset_mid_hold();
        test_contention();
        test_late();
        test_flush();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
